sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
Input conditioner for the board slide switches and enable switch, placed directly upstream of the 8-to-3 priority encoder / seven-segment stage.
- Synchronises each raw switch line to clk.
- Debounces it by requiring STABLE_CYC consecutive cycles of a new level.
- Presents clean, glitch-free levels plus one-cycle rise/fall/change pulses to the encoder and to any event logic.

Parameters:
- WIDTH, 8: number of data switches (sw_in/sw_out width).
- STABLE_CYC, 1000000: consecutive mismatching cycles before a new level is accepted (10 ms at 100 MHz). Legal range 1..2^24-1. Benches use 4.
- CNT_W (localparam), $clog2(STABLE_CYC+1): debounce counter width. Not overridable.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw_in  input  WIDTH  raw, asynchronous, bouncing switch levels.
- en_in  input  1  raw enable switch level.
- sw_out  output  WIDTH  debounced switch levels; feeds encoder x.
- en_out  output  1  debounced enable; feeds encoder en.
- rise  output  WIDTH  one-cycle pulse per bit when sw_out[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse per bit when sw_out[i] goes 1->0.
- changed  output  1  one-cycle pulse when any sw_out bit or en_out changes.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset state: all outputs 0. All synchroniser flops, stable registers and counters are 0.
  - Reset asserts asynchronously at any time, including mid-count.
  - After release, any input held high is re-acquired as a normal 0->1 change, with rise/changed pulses.
- Channels: WIDTH+1 identical channels (sw_in bits plus en_in). en is channel WIDTH and produces no rise/fall bit, only contributes to changed.
- Per-channel synchroniser: s1 <= raw, s2 <= s1 on every edge.
- Per-channel counter cnt, evaluated each edge on registered s2 vs stable:
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt < STABLE_CYC-1: cnt <= cnt+1.
  - s2 != stable and cnt == STABLE_CYC-1: stable <= s2, cnt <= 0.
- Latency: raw level first sampled at edge k and held thereafter -> sw_out/en_out updates at edge k+STABLE_CYC+1. Total of 2 sync stages plus STABLE_CYC samples.
- Glitch rejection: any mismatch run shorter than STABLE_CYC cycles leaves stable unchanged and emits no pulse. A single matching sample during bounce restarts the count from 0.
- Pulses:
  - rise[i], fall[i] and changed are registered.
  - They are set on the same edge stable updates, so they are high for exactly the one cycle in which the new sw_out value is first visible. They are 0 otherwise.
- Simultaneous events: channels are independent. Several bits updating on the same edge produce one changed pulse and the union of rise/fall bits. Mixed rise and fall on one edge is legal.
- No wrap-around: cnt never exceeds STABLE_CYC-1.
- Outputs are fully registered; no combinational path from sw_in to any output.
- Elaboration error if STABLE_CYC == 0.

Decomposition:
- Shared package sw_pkg holds:
  - DEBOUNCE_CYC_HW = 1000000
  - DEBOUNCE_CYC_SIM = 4
  - SW_WIDTH = 8
- Sub-module debounce_bit: one channel (sync, counter, stable, rise/fall pulse), parameterised by STABLE_CYC.
  - sw_debounce instantiates it WIDTH+1 times in a generate loop.
  - changed is registered as the OR of the per-channel update strobes.

Test Plan (STABLE_CYC=4):
1. Reset with sw_in=8'hFF, en_in=1 -> all outputs 0 while rst_n=0. Release before edge k -> sw_out=8'hFF and en_out=1 at edge k+5; rise=8'hFF and changed=1 for one cycle, then 0.
2. Clean step: from sw_out=0, sw_in=8'h24 first sampled at edge k -> sw_out=8'h24 at edge k+5; rise=8'h24 one cycle; fall=0; changed one cycle.
3. Glitch: sw_in[3] high for 3 cycles then low -> sw_out stays 8'h00; rise, fall and changed never assert.
4. Bounce: sw_in[0] toggles 1,0,1,0,1 on successive cycles, then held 1 from edge j -> sw_out[0]=1 exactly at edge j+5; exactly one rise[0] pulse.
5. Mixed: sw_out=8'h0F, sw_in switched to 8'hF0 in one cycle -> single update edge with sw_out=8'hF0, rise=8'hF0, fall=8'h0F, changed=1 for one cycle. Separately, en_in 1->0 alone -> en_out=0 after 5 edges, changed=1, rise=fall=0.
6. Reset mid-count: sw_in 0->8'h01, rst_n pulsed low after 2 mismatch cycles -> outputs and counters immediately 0. After release, sw_out[0]=1 after a full 5 edges (no partial-count carry-over).

Source files
------------

// File: rtl/sw_pkg.sv
// Shared constants for the switch conditioning path in front of the
// priority encoder / seven-segment stage.
package sw_pkg;

    localparam int unsigned DEBOUNCE_CYC_HW  = 1000000;
    localparam int unsigned DEBOUNCE_CYC_SIM = 4;
    localparam int unsigned SW_WIDTH         = 8;

    // Largest debounce window the counter is sized for.
    localparam int unsigned DEBOUNCE_CYC_MAX = (1 << 24) - 1;

endpackage : sw_pkg

// File: rtl/sw_debounce_bit.sv
// One switch channel: two-flop synchroniser, debounce counter, stable level
// and registered rise/fall pulses plus an unregistered update strobe.
module debounce_bit
    import sw_pkg::*;
#(
    parameter int unsigned STABLE_CYC = DEBOUNCE_CYC_HW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic stable_out,
    output logic rise_out,
    output logic fall_out,
    output logic update_out
);

    localparam int unsigned     CNT_W    = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

    if (STABLE_CYC == 0) begin : g_bad_zero
        $error("debounce_bit: STABLE_CYC must be at least 1");
    end
    if (STABLE_CYC > DEBOUNCE_CYC_MAX) begin : g_bad_big
        $error("debounce_bit: STABLE_CYC exceeds 2^24-1");
    end

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             update;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        s1_d     = raw_in;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        update   = 1'b0;

        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                // Mismatch held for the full window: accept the new level.
                stable_d = s2_q;
                rise_d   = s2_q;
                fall_d   = ~s2_q;
                update   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_out = stable_q;
    assign rise_out   = rise_q;
    assign fall_out   = fall_q;
    assign update_out = update;

endmodule : debounce_bit

// File: rtl/sw_debounce.sv
// Debounced slide switches and enable switch with one-cycle edge pulses;
// all outputs are registered.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int unsigned WIDTH      = SW_WIDTH,
    parameter int unsigned STABLE_CYC = DEBOUNCE_CYC_HW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             en_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             en_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    if (STABLE_CYC == 0) begin : g_bad_zero
        $error("sw_debounce: STABLE_CYC must be at least 1");
    end

    // Channel WIDTH is the enable switch; the rest are the data switches.
    logic [WIDTH:0] raw_vec;
    logic [WIDTH:0] stable_vec;
    logic [WIDTH:0] rise_vec;
    logic [WIDTH:0] fall_vec;
    logic [WIDTH:0] update_vec;
    logic [1:0]     en_edge_unused;

    assign raw_vec = {en_in, sw_in};

    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_chan
        debounce_bit #(
            .STABLE_CYC (STABLE_CYC)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw_in     (raw_vec[gi]),
            .stable_out (stable_vec[gi]),
            .rise_out   (rise_vec[gi]),
            .fall_out   (fall_vec[gi]),
            .update_out (update_vec[gi])
        );
    end

    // The enable channel only contributes to changed.
    assign en_edge_unused = {rise_vec[WIDTH], fall_vec[WIDTH]};

    logic changed_q, changed_d;

    always_comb begin
        changed_d = |update_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign sw_out  = stable_vec[WIDTH-1:0];
    assign en_out  = stable_vec[WIDTH];
    assign rise    = rise_vec[WIDTH-1:0];
    assign fall    = fall_vec[WIDTH-1:0];
    assign changed = changed_q;

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with STABLE_CYC=4: stimulus pushes the
// expected update (edge number and output values), a monitor pops on changed.
module tb_sw_debounce;
    import sw_pkg::*;

    localparam int W   = SW_WIDTH;
    localparam int SC  = DEBOUNCE_CYC_SIM;
    localparam int LAT = SC + 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_in = '0;
    logic         en_in = 1'b0;
    logic [W-1:0] sw_out;
    logic         en_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    sw_debounce #(
        .WIDTH      (W),
        .STABLE_CYC (SC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_in   (sw_in),
        .en_in   (en_in),
        .sw_out  (sw_out),
        .en_out  (en_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number n, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [W-1:0] sw;
        logic         en;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every update must match the head of the scoreboard; between
    // updates the levels hold and no edge pulse may appear.
    exp_t         mon_e;
    logic [W-1:0] prev_sw = '0;
    logic         prev_en = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sw = '0;
            prev_en = 1'b0;
        end else if (changed) begin
            if (sb_q.size() == 0) begin
                check("unexpected_change", {sw_out, en_out}, {prev_sw, prev_en});
                check("unexpected_change_pulse", 64'(changed), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("update_edge", 64'(cyc), 64'(mon_e.cyc));
                check("update_sw_out", 64'(sw_out), 64'(mon_e.sw));
                check("update_en_out", 64'(en_out), 64'(mon_e.en));
                check("update_rise", 64'(rise), 64'(mon_e.rise));
                check("update_fall", 64'(fall), 64'(mon_e.fall));
            end
            prev_sw = sw_out;
            prev_en = en_out;
        end else begin
            check("idle_pulses", 64'({rise, fall}), 64'd0);
            check("idle_hold", 64'({sw_out, en_out}), 64'({prev_sw, prev_en}));
        end
    end

    task automatic drive(input logic [W-1:0] sw, input logic en, output int k);
        @(negedge clk);
        sw_in = sw;
        en_in = en;
        k     = cyc + 1;
    endtask

    task automatic expect_update(input int c, input logic [W-1:0] sw, input logic en,
                                 input logic [W-1:0] r, input logic [W-1:0] f);
        exp_t e;
        e.cyc  = c;
        e.sw   = sw;
        e.en   = en;
        e.rise = r;
        e.fall = f;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({sw_out, en_out, rise, fall, changed}), 64'd0);
    endtask

    int k;

    initial begin
        // 1. Reset with all inputs high, then re-acquire as a normal rise.
        sw_in = 8'hFF;
        en_in = 1'b1;
        idle(3);
        check_all_zero("reset_outputs");
        #2 rst_n = 1'b1;
        k = cyc + 1;
        expect_update(k + LAT, 8'hFF, 1'b1, 8'hFF, 8'h00);
        idle(10);

        // 2. Clean step: back to zero, then 8'h24.
        drive(8'h00, 1'b1, k);
        expect_update(k + LAT, 8'h00, 1'b1, 8'h00, 8'hFF);
        idle(10);
        drive(8'h24, 1'b1, k);
        expect_update(k + LAT, 8'h24, 1'b1, 8'h24, 8'h00);
        idle(10);

        // 3. Glitch: bit 3 high for 3 samples only.
        drive(8'h2C, 1'b1, k);
        idle(2);
        drive(8'h24, 1'b1, k);
        idle(10);
        check("glitch_sw_out", 64'(sw_out), 64'h24);

        // 4. Bounce on bit 0: 1,0,1,0 then held 1 from edge k.
        drive(8'h25, 1'b1, k);
        drive(8'h24, 1'b1, k);
        drive(8'h25, 1'b1, k);
        drive(8'h24, 1'b1, k);
        drive(8'h25, 1'b1, k);
        expect_update(k + LAT, 8'h25, 1'b1, 8'h01, 8'h00);
        idle(12);

        // 5. Mixed rise/fall on one edge, then enable alone.
        drive(8'h0F, 1'b1, k);
        expect_update(k + LAT, 8'h0F, 1'b1, 8'h0A, 8'h20);
        idle(10);
        drive(8'hF0, 1'b1, k);
        expect_update(k + LAT, 8'hF0, 1'b1, 8'hF0, 8'h0F);
        idle(10);
        drive(8'hF0, 1'b0, k);
        expect_update(k + LAT, 8'hF0, 1'b0, 8'h00, 8'h00);
        idle(10);

        // 6. Reset mid-count: no partial count survives.
        drive(8'h00, 1'b0, k);
        expect_update(k + LAT, 8'h00, 1'b0, 8'h00, 8'hF0);
        idle(10);
        drive(8'h01, 1'b0, k);
        idle(4);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midcount_reset_outputs");
        idle(1);
        #2 rst_n = 1'b1;
        k = cyc + 1;
        expect_update(k + LAT, 8'h01, 1'b0, 8'h01, 8'h00);
        idle(12);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sw_debounce
